// File: rtl/alu_arbiter_if.sv
// ALU function encodings and the request/response/ALU bundle for alu_arbiter.
// The requester and ALU side uses "master"; the arbiter uses "slave".
package ALU_FNS;
    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } alu_fn_t;

    typedef enum logic [6:0] {
        ADD_SRL = 7'h00,
        SUB_SRA = 7'h20
    } funct7_t;
endpackage

interface alu_arbiter_if #(parameter int WIDTH = 32);
    import ALU_FNS::*;

    logic             req0_valid;
    logic             req0_ready;
    alu_fn_t          req0_fn;
    funct7_t          req0_funct7;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    alu_fn_t          req1_fn;
    funct7_t          req1_funct7;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_out;
    logic             rsp0_take_branch;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_out;
    logic             rsp1_take_branch;

    alu_fn_t          alu_fn;
    funct7_t          alu_funct7;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_take_branch;

    modport slave (
        input  req0_valid, req0_fn, req0_funct7, req0_a, req0_b,
        input  req1_valid, req1_fn, req1_funct7, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        input  alu_out, alu_take_branch,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_out, rsp0_take_branch,
        output rsp1_valid, rsp1_out, rsp1_take_branch,
        output alu_fn, alu_funct7, alu_a, alu_b
    );

    modport master (
        output req0_valid, req0_fn, req0_funct7, req0_a, req0_b,
        output req1_valid, req1_fn, req1_funct7, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        output alu_out, alu_take_branch,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_out, rsp0_take_branch,
        input  rsp1_valid, rsp1_out, rsp1_take_branch,
        input  alu_fn, alu_funct7, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One-cycle latency into a per-requester response slot; a full, unconsumed slot blocks its requester.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    alu_arbiter_if.slave bus
);
    import ALU_FNS::*;

    logic             elig0, elig1;
    logic             grant0, grant1;
    logic             last_grant;
    logic             rsp0_valid_q, rsp1_valid_q;
    logic [WIDTH-1:0] rsp0_out_q, rsp1_out_q;
    logic             rsp0_tb_q, rsp1_tb_q;

    // A slot that drains this cycle can be refilled in the same cycle.
    assign elig0 = bus.req0_valid && (!rsp0_valid_q || bus.rsp0_ready);
    assign elig1 = bus.req1_valid && (!rsp1_valid_q || bus.rsp1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        bus.alu_fn     = ADD_SUB;
        bus.alu_funct7 = ADD_SRL;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        if (grant0) begin
            bus.alu_fn     = bus.req0_fn;
            bus.alu_funct7 = bus.req0_funct7;
            bus.alu_a      = bus.req0_a;
            bus.alu_b      = bus.req0_b;
        end else if (grant1) begin
            bus.alu_fn     = bus.req1_fn;
            bus.alu_funct7 = bus.req1_funct7;
            bus.alu_a      = bus.req1_a;
            bus.alu_b      = bus.req1_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp0_out_q   <= '0;
            rsp0_tb_q    <= 1'b0;
        end else if (grant0) begin
            rsp0_valid_q <= 1'b1;
            rsp0_out_q   <= bus.alu_out;
            rsp0_tb_q    <= bus.alu_take_branch;
        end else if (bus.rsp0_ready) begin
            rsp0_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid_q <= 1'b0;
            rsp1_out_q   <= '0;
            rsp1_tb_q    <= 1'b0;
        end else if (grant1) begin
            rsp1_valid_q <= 1'b1;
            rsp1_out_q   <= bus.alu_out;
            rsp1_tb_q    <= bus.alu_take_branch;
        end else if (bus.rsp1_ready) begin
            rsp1_valid_q <= 1'b0;
        end
    end

    // Reset to 1 so requester 0 wins the first tie; idle cycles leave priority alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant <= grant1;
        end
    end

    assign bus.rsp0_valid       = rsp0_valid_q;
    assign bus.rsp0_out         = rsp0_out_q;
    assign bus.rsp0_take_branch = rsp0_tb_q;
    assign bus.rsp1_valid       = rsp1_valid_q;
    assign bus.rsp1_out         = rsp1_out_q;
    assign bus.rsp1_take_branch = rsp1_tb_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` instance between two requesters, for example the execute stage (port 0) and the branch/address unit (port 1). Each requester drives a valid/ready request channel carrying `fn`, `funct7`, `a` and `b`. The arbiter grants at most one request per cycle using round-robin priority, drives the ALU from the granted operands, and captures the result in a per-requester response register. The response is returned on a valid/ready response channel with one-cycle latency.

## Interface
- `WIDTH`, 32, operand/result width; must match the `alu` instance.

- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request granted this cycle.
- `req0_fn`, `req1_fn`  in  `alu_fn_t`  ALU function (`ALU_FNS` package).
- `req0_funct7`, `req1_funct7`  in  `funct7_t`  `ADD_SRL` / `SUB_SRA` select.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `rsp0_valid`, `rsp1_valid`  out  1  response held.
- `rsp0_ready`, `rsp1_ready`  in  1  requester consumes the response.
- `rsp0_out`, `rsp1_out`  out  WIDTH  captured ALU result.
- `rsp0_take_branch`, `rsp1_take_branch`  out  1  captured branch flag.
- `alu_fn`, `alu_funct7`  out  `alu_fn_t` / `funct7_t`  to ALU.
- `alu_a`, `alu_b`  out  WIDTH  to ALU.
- `alu_out`  in  WIDTH  from ALU.
- `alu_take_branch`  in  1  from ALU.

## Operation
- **Eligibility.** Requester N is eligible when both hold:
  - `reqN_valid` = 1;
  - its response slot is free or drains this cycle: `!rspN_valid || rspN_ready`.
- **Grant.**
  - Only one requester eligible: it is granted.
  - Both eligible: the requester not granted most recently is granted.
  - Neither eligible: no grant.
  - `reqN_ready` = grant N; this path is combinational from valid/eligibility.
  - Exactly one `reqN_ready` is high per cycle, or none.
  - `reqN_ready` never asserts while requester N is ineligible.
- **Accept.** A request is accepted when `reqN_valid && reqN_ready`.
- **ALU drive.**
  - `alu_*` carries the granted requester's `fn`/`funct7`/`a`/`b`, combinationally.
  - With no grant: `alu_fn` = `ADD_SUB`, `alu_funct7` = `ADD_SRL`, `alu_a` = `alu_b` = 0.
- **Capture.** On an accept by requester N, at the clock edge:
  - `rspN_out` ← `alu_out`;
  - `rspN_take_branch` ← `alu_take_branch`;
  - `rspN_valid` ← 1.
- **Response hold.**
  - `rspN_valid` clears on `rspN_ready` when there is no new accept for N that cycle.
  - Consume and accept in the same cycle: `rspN_valid` stays 1 and the data is replaced.
  - Response data is held stable while `rspN_valid` && !`rspN_ready`.
- **Round-robin pointer.** The `last_grant` register updates only on accept. An idle cycle does not move priority.
- **Results.** The arbiter performs no arithmetic. Results are exactly what the ALU produces.
- **Ordering.** Each requester has at most one outstanding response. Per-requester ordering is preserved trivially.

## Timing
- **Reset** (asynchronous, `rst_n` = 0), effective immediately:
  - `rsp0_valid` = `rsp1_valid` = 0;
  - `rsp*_out` = 0;
  - `rsp*_take_branch` = 0;
  - `last_grant` = 1, so requester 0 wins the first tie.
  - `req*_ready` then follow the grant rule, with both slots free.
- **Mid-operation reset:** captured responses are discarded and nothing is replayed.
- **Latency:** request accepted in cycle T → `rspN_valid` = 1 with result in cycle T+1.
- **Throughput:**
  - One accept per cycle in aggregate.
  - A single requester with `rspN_ready` held at 1 sustains one operation per cycle.
  - Both requesters continuously valid → grants alternate 0,1,0,1.
- **Back-pressure:**
  - While `rspN_valid` = 1 and `rspN_ready` = 0, `reqN_ready` = 0.
  - During that time the other requester is granted every cycle it is valid.
- **Request side:** requesters must hold `reqN_*` stable until accepted. The arbiter does not register requests.

## Test plan
- **Single op, port 0 only:**
  - Stimulus: `fn`=`ADD_SUB`, `funct7`=`ADD_SRL`, a=5, b=6, `rsp0_ready`=1.
  - Required: `req0_ready`=1 in T; `rsp0_valid`=1 and `rsp0_out`=0x0000000B in T+1.
  - Repeat with `SUB_SRA`: `rsp0_out`=0xFFFFFFFF.
- **Tie and alternation, both ports valid every cycle after reset:**
  - Port 0 is `AND` 0xF0F0F0F0/0xFF00FF00; port 1 is `OR` with the same operands.
  - Required grants: 0,1,0,1.
  - Required responses: `rsp0_out`=0xF000F000, `rsp1_out`=0xFFF0FFF0.
- **Back-pressure on port 0:**
  - Stimulus: `rsp0_ready`=0 after the first accept; both ports keep requesting.
  - Required: `req0_ready` stays 0, `rsp0_out` stays stable, and port 1 is granted every cycle.
  - Then raise `rsp0_ready` for one cycle: port 0 is accepted that same cycle, and `rsp0_valid` stays 1 with new data.
- **Sustained single-port stream:**
  - Stimulus: port 1 issues `SLL` a=1 with b=0..31 on consecutive cycles, `rsp1_ready`=1.
  - Required: 32 consecutive responses 1<<b with no bubbles.
- **Asynchronous reset mid-stream:**
  - Stimulus: assert `rst_n`=0 between clock edges while `rsp0_valid`=1.
  - Required: `rsp0_valid`/`rsp1_valid` drop to 0 immediately and `rsp*_out`=0.
  - After release, the first tie grants port 0.
- **Idle:**
  - Stimulus: no valids.
  - Required: `alu_fn`=`ADD_SUB`, `alu_funct7`=`ADD_SRL`, `alu_a`=`alu_b`=0, `last_grant` unchanged, `rsp*_valid` hold their values.
